cordic_result_collector: RTL and testbench
==========================================

Name: cordic_result_collector

Overview:
- Sits directly downstream of the 16-stage pipelined CORDIC rotator; consumes its Xout/Yout.
- The CORDIC has no valid or stall, so this block tracks issued operations through a valid shift pipe matched to the CORDIC latency.
- Applies 1/K gain compensation with rounding and saturation, then buffers results in a small FIFO with a ready/valid output.
- Issues credit-based `in_ready` upstream, so no result that has been issued is ever dropped.

Parameters:
- XY_SZ, 16, CORDIC data width; inputs are XY_SZ+1 bits signed.
- LATENCY, 16, clock cycles from angle/in presented to the CORDIC until the matching Xout/Yout is valid.
- FIFO_DEPTH, 4, result FIFO entries; power of 2, ≥2.
- GAIN, 19898, unsigned Q1.15 value of 1/K (0.607253).
- OUT_W, 16, signed output width.

Ports:
- clock  in  1  rising-edge clock, shared with the CORDIC.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream presents angle/in to the CORDIC this cycle.
- in_ready  out  1  collector can accept an issue this cycle.
- x_in  in  XY_SZ+1  CORDIC Xout, signed.
- y_in  in  XY_SZ+1  CORDIC Yout, signed.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  downstream accepts the head.
- out_x  out  OUT_W  compensated X at the FIFO head.
- out_y  out  OUT_W  compensated Y at the FIFO head.
- out_sat  out  1  head entry was saturated (X or Y).
- overflow  out  1  sticky error flag; write attempted while the FIFO was full.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: out_valid=0, out_x=0, out_y=0, out_sat=0, overflow=0, in_ready=1.
- On reset, the valid pipe, FIFO pointers and count all clear; results in flight are discarded.
- Reset asserted mid-operation takes effect on that edge, regardless of in_valid/out_ready.
- Issue accept: accept = in_valid & in_ready.
  - Only accepted issues are tracked.
  - With in_valid=1 and in_ready=0, the CORDIC result is ignored; upstream must hold and retry.
- Valid pipe: a shift register of LATENCY+1 bits.
  - Bit 0 loads accept.
  - Tap [LATENCY-1] marks x_in/y_in valid for the current cycle.
  - Tap [LATENCY] marks the registered product valid, which is the FIFO write enable.
- Arithmetic stage (1 register):
  - p = x_in * GAIN, signed × unsigned positive, (XY_SZ+1+16) bits; same for y_in.
  - r = (p + 2^14) >>> 15, i.e. round-half-up, arithmetic shift.
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - sat = 1 if either axis clipped.
- Total latency: issue → FIFO write = LATENCY+1 cycles; out_valid follows 1 cycle later (registered FIFO count).
  - Accept at cycle 0 gives out_valid=1 at cycle LATENCY+2 when the FIFO was empty.
- FIFO:
  - Write on tap [LATENCY]; read on out_valid & out_ready.
  - Simultaneous read and write: count unchanged, both pointers advance.
  - Pointers wrap modulo FIFO_DEPTH.
  - out_x, out_y and out_sat always show the head entry; they hold while out_valid & !out_ready.
- Credit:
  - in_flight = popcount of the valid pipe.
  - in_ready = (fifo_count + in_flight) < FIFO_DEPTH, computed combinationally from registered state.
  - A read in the current cycle does not free a credit until the next cycle.
  - Back-to-back accepts are allowed while credit remains.
- overflow: set if a write occurs while the FIFO is full; cleared only by reset. Unreachable when upstream obeys in_ready.

Optional Feature:
- Macro: CORDIC_GAIN_COMP_EN.
- Defined:
  - Multiply/round stage as above.
  - Valid pipe is LATENCY+1 bits.
- Undefined:
  - No multiplier; x_in/y_in are saturated directly to OUT_W.
  - Valid pipe is LATENCY bits; FIFO write is on tap [LATENCY-1].
  - Issue → write latency is LATENCY.
  - Credit uses the shorter pipe.

Test Plan:
- Basic result, gain on: reset 2 cycles, accept one issue; at tap, x_in=26349, y_in=0 → out_x=16000, out_y=0, out_sat=0, out_valid rises at cycle 18.
- Saturation: x_in=65535, y_in=-65536 → out_x=32767, out_y=-32768, out_sat=1.
- Credit/backpressure: out_ready=0, in_valid=1 continuously → exactly 4 accepts, then in_ready=0. FIFO fills to 4 and overflow stays 0. Raising out_ready drains 4 results in order, and in_ready returns.
- Simultaneous read/write: with the FIFO holding 2 entries and out_ready=1, feed a steady stream → count constant, sequential x_in tags appear in order, no gaps or duplicates.
- Reset mid-flight: 3 accepts issued, then reset at cycle 5 → no out_valid afterwards, in_ready=1 the cycle after reset, all outputs 0.
- Macro undefined: x_in=26349 → out_x=26349 at write cycle 16. x_in=40000 → out_x=32767, out_sat=1.

Source files
------------

// File: rtl/cordic_result_collector.sv
// cordic_result_collector: tracks CORDIC issues, compensates 1/K gain when CORDIC_GAIN_COMP_EN is defined, buffers results.
// Latency: issue to FIFO write is LATENCY+1 with gain compensation, LATENCY without; out_valid follows one cycle later.
// Backpressure: in_ready grants an issue only while FIFO entries plus in-flight issues stay below FIFO_DEPTH.
module cordic_result_collector #(
    parameter int XY_SZ      = 16,
    parameter int LATENCY    = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int GAIN       = 19898,
    parameter int OUT_W      = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [XY_SZ:0]   x_in,
    input  logic signed [XY_SZ:0]   y_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_x,
    output logic signed [OUT_W-1:0] out_y,
    output logic                    out_sat,
    output logic                    overflow
);

`ifdef CORDIC_GAIN_COMP_EN
    localparam int PIPE_W = LATENCY + 1;
`else
    localparam int PIPE_W = LATENCY;
`endif
    localparam int WR_TAP = PIPE_W - 1;
    localparam int P_W    = XY_SZ + 1 + 16;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CW     = $clog2(PIPE_W + FIFO_DEPTH + 1);
    localparam logic signed [P_W-1:0] SAT_MAX = P_W'(2**(OUT_W-1) - 1);
    localparam logic signed [P_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef struct packed {
        logic                    sat;
        logic signed [OUT_W-1:0] x;
        logic signed [OUT_W-1:0] y;
    } res_t;

    // Returns {clipped, value} with value clamped to the signed OUT_W range.
    function automatic logic [OUT_W:0] sat_f(input logic signed [P_W-1:0] v);
        logic [OUT_W:0] r;
        if (v > SAT_MAX)
            r = {1'b1, SAT_MAX[OUT_W-1:0]};
        else if (v < SAT_MIN)
            r = {1'b1, SAT_MIN[OUT_W-1:0]};
        else
            r = {1'b0, v[OUT_W-1:0]};
        return r;
    endfunction

    function automatic logic signed [P_W-1:0] sext(input logic signed [XY_SZ:0] v);
        return {{(P_W-XY_SZ-1){v[XY_SZ]}}, v};
    endfunction

    logic [PIPE_W-1:0] vpipe_q, vpipe_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              ovf_q, ovf_d;
    res_t              mem_q [FIFO_DEPTH];
    res_t              mem_d [FIFO_DEPTH];
    res_t              wr_dat;
    logic [CW-1:0]     in_flight;
    logic              accept, wr_en, rd_en, full;
    logic [OUT_W:0]    sx, sy;

    // Credits come from registered state only, so a read frees a slot one cycle later.
    always_comb begin
        in_flight = '0;
        for (int i = 0; i < PIPE_W; i++)
            in_flight = in_flight + CW'(vpipe_q[i]);
        in_ready = (CW'(count_q) + in_flight) < CW'(FIFO_DEPTH);
        accept   = in_valid & in_ready;
        vpipe_d  = {vpipe_q[PIPE_W-2:0], accept};
    end

`ifdef CORDIC_GAIN_COMP_EN
    localparam logic signed [P_W-1:0] GAIN_S = P_W'(GAIN);
    localparam logic signed [P_W-1:0] RND    = P_W'(2**14);

    logic signed [P_W-1:0] px, py, rx, ry;
    res_t                  res_q, res_d;

    always_comb begin
        px = sext(x_in) * GAIN_S;
        py = sext(y_in) * GAIN_S;
        rx = (px + RND) >>> 15;
        ry = (py + RND) >>> 15;
        sx = sat_f(rx);
        sy = sat_f(ry);
        res_d = res_q;
        if (vpipe_q[LATENCY-1]) begin
            res_d.sat = sx[OUT_W] | sy[OUT_W];
            res_d.x   = sx[OUT_W-1:0];
            res_d.y   = sy[OUT_W-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            res_q <= '0;
        else
            res_q <= res_d;
    end

    assign wr_dat = res_q;
`else
    always_comb begin
        sx         = sat_f(sext(x_in));
        sy         = sat_f(sext(y_in));
        wr_dat.sat = sx[OUT_W] | sy[OUT_W];
        wr_dat.x   = sx[OUT_W-1:0];
        wr_dat.y   = sy[OUT_W-1:0];
    end
`endif

    always_comb begin
        wr_en    = vpipe_q[WR_TAP];
        rd_en    = out_valid & out_ready;
        full     = (count_q == (AW+1)'(FIFO_DEPTH));
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (wr_en & full);
        // A write into a full FIFO still lands if the head leaves on the same edge.
        if (wr_en && (!full || rd_en)) begin
            mem_d[wr_ptr_q] = wr_dat;
            wr_ptr_d        = wr_ptr_q + AW'(1);
            count_d         = count_q + (AW+1)'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            count_d  = count_d - (AW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vpipe_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            vpipe_q  <= vpipe_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            mem_q    <= mem_d;
        end
    end

    assign out_valid = (count_q != '0);
    assign out_x     = mem_q[rd_ptr_q].x;
    assign out_y     = mem_q[rd_ptr_q].y;
    assign out_sat   = mem_q[rd_ptr_q].sat;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_cordic_result_collector.sv
// Directed bench for cordic_result_collector; a delay line stands in for the CORDIC pipeline.
// Expected values follow CORDIC_GAIN_COMP_EN the same way the design build does.
module tb_cordic_result_collector;

    localparam int LATENCY = 16;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT_OUT = LATENCY + 2;
`else
    localparam int LAT_OUT = LATENCY + 1;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic in_ready, out_valid, out_sat, overflow;
    logic signed [16:0] x_in, y_in;
    logic signed [16:0] issue_x = '0;
    logic signed [16:0] issue_y = '0;
    logic signed [15:0] out_x, out_y;
    logic signed [16:0] dx [LATENCY];
    logic signed [16:0] dy [LATENCY];

    int total = 0;
    int bad = 0;
    int acc, n_acc, n_pop, hold, seen, v;

    cordic_result_collector dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_sat   (out_sat),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        dx[0] <= issue_x;
        dy[0] <= issue_y;
        for (int i = 1; i < LATENCY; i++) begin
            dx[i] <= dx[i-1];
            dy[i] <= dy[i-1];
        end
    end
    assign x_in = dx[LATENCY-1];
    assign y_in = dy[LATENCY-1];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_f(input int val);
        longint r;
`ifdef CORDIC_GAIN_COMP_EN
        r = (longint'(val) * 19898 + 16384) >>> 15;
`else
        r = val;
`endif
        if (r > 32767) return 32767;
        if (r < -32768) return -32768;
        return int'(r);
    endfunction

    task automatic run_one(input string tag, input int x, input int y,
                           input int ex, input int ey, input int es);
        issue_x  = 17'(x);
        issue_y  = 17'(y);
        in_valid = 1'b1;
        chk({tag, "_rdy"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        repeat (LAT_OUT - 2) tick();
        chk({tag, "_early"}, out_valid, 0);
        tick();
        chk({tag, "_vld"}, out_valid, 1);
        chk({tag, "_x"}, out_x, ex);
        chk({tag, "_y"}, out_y, ey);
        chk({tag, "_sat"}, out_sat, es);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_pop"}, out_valid, 0);
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        chk("rst_vld", out_valid, 0);
        chk("rst_x", out_x, 0);
        chk("rst_y", out_y, 0);
        chk("rst_sat", out_sat, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_rdy", in_ready, 1);

`ifdef CORDIC_GAIN_COMP_EN
        run_one("basic", 26349, 0, 16000, 0, 0);
        run_one("satur", 65535, -65536, 32767, -32768, 1);
        run_one("big", 40000, 0, 24290, 0, 0);
        run_one("round", -3, 1, -2, 1, 0);
`else
        run_one("basic", 26349, 0, 26349, 0, 0);
        run_one("satur", 65535, -65536, 32767, -32768, 1);
        run_one("big", 40000, 0, 32767, 0, 1);
        run_one("round", -3, 1, -3, 1, 0);
`endif

        // Credit exhaustion with the output stalled.
        acc = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            issue_x = 17'(1000 + 100 * acc);
            issue_y = 17'(-(1000 + 100 * acc));
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        chk("credit_acc", acc, 4);
        chk("credit_rdy", in_ready, 0);
        chk("credit_vld", out_valid, 1);
        chk("credit_ovf", overflow, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("drain_vld", out_valid, 1);
            chk("drain_x", out_x, ref_f(1000 + 100 * k));
            chk("drain_y", out_y, ref_f(-(1000 + 100 * k)));
            tick();
        end
        out_ready = 1'b0;
        chk("drain_empty", out_valid, 0);
        chk("drain_rdy", in_ready, 1);

        // Steady stream with reads overlapping writes once two entries are queued.
        n_acc = 0;
        n_pop = 0;
        hold = 0;
        for (int c = 0; c < 140; c++) begin
            in_valid = (c < 100);
            issue_x = 17'(100 * n_acc + 7);
            issue_y = 17'(-(100 * n_acc + 7));
            if (!out_ready && out_valid) begin
                hold++;
                if (hold == 2) out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                chk("stream_x", out_x, ref_f(100 * n_pop + 7));
                chk("stream_y", out_y, ref_f(-(100 * n_pop + 7)));
                n_pop++;
            end
            if (in_valid && in_ready) n_acc++;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("stream_count", n_pop, n_acc);
        v = (n_acc >= 12) ? 1 : 0;
        chk("stream_rate", v, 1);
        chk("stream_ovf", overflow, 0);

        // Reset with three issues still in the pipe.
        in_valid = 1'b1;
        issue_x = 17'(500);
        issue_y = 17'(-500);
        for (int c = 0; c < 3; c++) begin
            chk("mid_rdy", in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("mid_rst_rdy", in_ready, 1);
        chk("mid_rst_vld", out_valid, 0);
        chk("mid_rst_x", out_x, 0);
        chk("mid_rst_y", out_y, 0);
        chk("mid_rst_sat", out_sat, 0);
        chk("mid_rst_ovf", overflow, 0);
        seen = 0;
        repeat (LATENCY + 6) begin
            if (out_valid) seen = 1;
            tick();
        end
        chk("mid_rst_quiet", seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
